shot_resolver: RTL and testbench
================================

# shot_resolver

Resolves one incoming enemy shot against the player's board memory. It reads the addressed 2-bit cell, writes back HIT or MISS, and reports the outcome to the game-control FSM. It keeps a running count of hit ship cells and flags defeat once every ship cell has been hit. It sits between the UART/turn controller, which supplies shot coordinates, and the player board RAM, which the grid renderer also reads.

## Interface
Parameters:
- GRID_DIM, 10, board side length; valid coordinates are 0..GRID_DIM-1.
- SHIP_CELLS, 20, total ship cells deployed (SHIPS_NUMBER = 10 ships, sizes 4,3,3,2,2,2,1,1,1,1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  new-game pulse; same effect as rst on this block.
- shot_valid  in  1  shot request; coordinates valid while high.
- shot_x  in  4  column of shot.
- shot_y  in  4  row of shot.
- shot_ready  out  1  block can accept a shot.
- mem_addr  out  7  board RAM address = shot_y*GRID_DIM + shot_x.
- mem_rdata  in  2  RAM read data; 1-cycle synchronous read latency.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  2  RAM write data.
- result_valid  out  1  one-cycle pulse; result_* fields valid.
- result_hit  out  1  shot hit a ship cell (new or already hit).
- result_repeat  out  1  cell had already been shot (MISS or HIT).
- result_invalid  out  1  coordinate out of range.
- hit_count  out  $clog2(SHIP_CELLS+1)  ship cells hit so far.
- all_ships_sunk  out  1  sticky; hit_count == SHIP_CELLS.

## Operation
- Cell encodings are taken from project_cfg_pkg: EMPTY=00, MYSHIP=01, MISS=10, HIT=11.
- The FSM has four states: IDLE, READ, EVAL, WRITE.
- IDLE:
  - shot_ready = 1 when all_ships_sunk = 0; otherwise 0 (game over, no further shots accepted).
  - On shot_valid && shot_ready, latch x/y and register mem_addr, then go to READ.
- READ: the RAM samples mem_addr. Go to EVAL.
- EVAL: mem_rdata is valid. Decide the outcome and register the results, then go to WRITE.
  - Out of range (x >= GRID_DIM or y >= GRID_DIM): invalid=1, hit=0, repeat=0, no write.
  - EMPTY: write MISS; hit=0, repeat=0.
  - MYSHIP: write HIT; hit=1, repeat=0; hit_count increments.
  - MISS: no write; hit=0, repeat=1.
  - HIT: no write; hit=1, repeat=1.
- WRITE:
  - mem_we is asserted for exactly this cycle when a write was decided.
  - result_valid pulses for this cycle.
  - hit_count and all_ships_sunk take their new values in this cycle.
  - Return to IDLE.
- hit_count saturates at SHIP_CELLS.
- all_ships_sunk rises in the same cycle that hit_count reaches SHIP_CELLS, and stays high until rst or clear.
- rst or clear, in any state:
  - next state is IDLE and the counter is zeroed.
  - An in-flight shot is dropped: no result_valid and no mem_we follow.
  - clear has priority over shot_valid in the same cycle.
- mem_addr is held stable from the handshake until the next handshake. It is not recomputed for out-of-range coordinates; the RAM read performed in that case is harmless.

## Timing
- Handshake in cycle 0, READ in cycle 1, EVAL in cycle 2, result_valid and mem_we in cycle 3, shot_ready high again in cycle 4.
- Throughput is one shot per 4 cycles.
- shot_valid may be held high; each handshake consumes exactly one shot.
- Coordinates are sampled only at the handshake; later changes are ignored.
- Reset values: shot_ready=1 (IDLE), mem_addr=0, mem_we=0, mem_wdata=0, result_valid=0, result_hit=0, result_repeat=0, result_invalid=0, hit_count=0, all_ships_sunk=0.
- result_* fields hold their last values between pulses.
- mem_wdata is meaningful only while mem_we = 1.

## Test plan
- RAM cell 23 = EMPTY; shot (3,2) at cycle 0 -> cycle 3: mem_addr=23, mem_we=1, mem_wdata=10, result_valid=1, hit=0, repeat=0; hit_count unchanged.
- Cell 45 = MYSHIP; shot (5,4) -> write 11 to 45, hit=1, hit_count 0->1. Fire the same shot again -> repeat=1, hit=1, no mem_we, hit_count stays 1.
- Shot (10,3) and shot (2,15) -> invalid=1, mem_we never asserted, latency still 3 cycles.
- Preload 20 MYSHIP cells and hit all 20 -> all_ships_sunk rises in the WRITE cycle of the 20th hit; shot_ready stays 0 afterwards; hit_count=20.
- clear asserted in EVAL of a MYSHIP shot -> no result_valid, no mem_we, hit_count=0, shot_ready=1 next cycle.
- shot_valid held high for 12 cycles with a fixed EMPTY target -> exactly 3 handshakes and 3 result pulses at cycles 3, 7, 11.

Source files
------------

// File: rtl/shot_resolver.sv
// shot_resolver: resolves one enemy shot against the player board RAM.
// Reads the addressed cell, writes back HIT/MISS, reports the outcome and
// tracks how many ship cells have been hit (defeat flag once all are hit).
module shot_resolver #(
    parameter int GRID_DIM   = 10,
    parameter int SHIP_CELLS = 20,
    localparam int CNT_W     = $clog2(SHIP_CELLS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shot_valid,
    input  logic [3:0]       shot_x,
    input  logic [3:0]       shot_y,
    output logic             shot_ready,
    output logic [6:0]       mem_addr,
    input  logic [1:0]       mem_rdata,
    output logic             mem_we,
    output logic [1:0]       mem_wdata,
    output logic             result_valid,
    output logic             result_hit,
    output logic             result_repeat,
    output logic             result_invalid,
    output logic [CNT_W-1:0] hit_count,
    output logic             all_ships_sunk
);

    // Board cell encodings shared with the renderer and placement logic.
    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_MYSHIP = 2'b01;
    localparam logic [1:0] CELL_MISS   = 2'b10;
    localparam logic [1:0] CELL_HIT    = 2'b11;

    localparam logic [CNT_W-1:0] SHIP_MAX = CNT_W'(SHIP_CELLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic             shot_ready_r;
    logic [6:0]       mem_addr_r;
    logic             in_range_r;
    logic             mem_we_r;
    logic [1:0]       mem_wdata_r;
    logic             result_valid_r;
    logic             result_hit_r;
    logic             result_repeat_r;
    logic             result_invalid_r;
    logic [CNT_W-1:0] hit_count_r;
    logic             sunk_r;

    logic             handshake_s;
    logic [7:0]       addr_wide_s;
    logic             in_range_s;
    logic             eval_we_s;
    logic [1:0]       eval_wdata_s;
    logic             eval_hit_s;
    logic             eval_rep_s;
    logic             eval_inv_s;
    logic             eval_inc_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sunk_next_s;

    // Out-of-range coordinates may wrap here; that read is harmless because
    // the in-range flag suppresses any write-back.
    assign handshake_s = shot_valid && shot_ready_r;
    assign addr_wide_s = 8'(shot_y) * 8'(GRID_DIM) + 8'(shot_x);
    assign in_range_s  = ({28'd0, shot_x} < $unsigned(GRID_DIM)) &&
                         ({28'd0, shot_y} < $unsigned(GRID_DIM));

    assign shot_ready     = shot_ready_r;
    assign mem_addr       = mem_addr_r;
    assign mem_we         = mem_we_r;
    assign mem_wdata      = mem_wdata_r;
    assign result_valid   = result_valid_r;
    assign result_hit     = result_hit_r;
    assign result_repeat  = result_repeat_r;
    assign result_invalid = result_invalid_r;
    assign hit_count      = hit_count_r;
    assign all_ships_sunk = sunk_r;

    // State register; rst and clear both abandon any shot in flight.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: fixed four-cycle walk once a shot is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ:  state_next_s = ST_EVAL;
            ST_EVAL:  state_next_s = ST_WRITE;
            ST_WRITE: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Outcome decode from the cell read back during EVAL.
    always_comb begin
        eval_we_s    = 1'b0;
        eval_wdata_s = mem_wdata_r;
        eval_hit_s   = 1'b0;
        eval_rep_s   = 1'b0;
        eval_inv_s   = 1'b0;
        eval_inc_s   = 1'b0;
        if (!in_range_r) begin
            eval_inv_s = 1'b1;
        end else begin
            case (mem_rdata)
                CELL_EMPTY: begin
                    eval_we_s    = 1'b1;
                    eval_wdata_s = CELL_MISS;
                end
                CELL_MYSHIP: begin
                    eval_we_s    = 1'b1;
                    eval_wdata_s = CELL_HIT;
                    eval_hit_s   = 1'b1;
                    eval_inc_s   = 1'b1;
                end
                CELL_MISS: begin
                    eval_rep_s = 1'b1;
                end
                CELL_HIT: begin
                    eval_hit_s = 1'b1;
                    eval_rep_s = 1'b1;
                end
                default: begin
                    eval_inv_s = 1'b0;
                end
            endcase
        end
    end

    // Saturating hit counter and the defeat flag derived from it.
    always_comb begin
        if (eval_inc_s && (hit_count_r != SHIP_MAX)) begin
            cnt_next_s = hit_count_r + CNT_W'(1);
        end else begin
            cnt_next_s = hit_count_r;
        end
        sunk_next_s = sunk_r || (cnt_next_s == SHIP_MAX);
    end

    // Output/datapath registers: everything the WRITE cycle shows is
    // captured on the EVAL->WRITE edge so it appears together.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shot_ready_r     <= 1'b1;
            mem_addr_r       <= 7'd0;
            in_range_r       <= 1'b0;
            mem_we_r         <= 1'b0;
            mem_wdata_r      <= 2'b00;
            result_valid_r   <= 1'b0;
            result_hit_r     <= 1'b0;
            result_repeat_r  <= 1'b0;
            result_invalid_r <= 1'b0;
            hit_count_r      <= '0;
            sunk_r           <= 1'b0;
        end else begin
            mem_we_r       <= 1'b0;
            result_valid_r <= 1'b0;
            // sunk_r is already final by the time the FSM returns to IDLE
            shot_ready_r   <= (state_next_s == ST_IDLE) && !sunk_r;
            if (handshake_s) begin
                mem_addr_r <= addr_wide_s[6:0];
                in_range_r <= in_range_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (state_r == ST_EVAL) begin
                mem_we_r         <= eval_we_s;
                mem_wdata_r      <= eval_wdata_s;
                result_valid_r   <= 1'b1;
                result_hit_r     <= eval_hit_s;
                result_repeat_r  <= eval_rep_s;
                result_invalid_r <= eval_inv_s;
                hit_count_r      <= cnt_next_s;
                sunk_r           <= sunk_next_s;
            end else begin
                hit_count_r <= hit_count_r;
            end
        end
    end

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver with a behavioural board RAM and a
// scoreboard of expected results keyed by the cycle they must appear in.
module tb_shot_resolver;

    localparam int GRID_DIM   = 10;
    localparam int SHIP_CELLS = 20;
    localparam int CNT_W      = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             shot_valid;
    logic [3:0]       shot_x;
    logic [3:0]       shot_y;
    logic             shot_ready;
    logic [6:0]       mem_addr;
    logic [1:0]       mem_rdata;
    logic             mem_we;
    logic [1:0]       mem_wdata;
    logic             result_valid;
    logic             result_hit;
    logic             result_repeat;
    logic             result_invalid;
    logic [CNT_W-1:0] hit_count;
    logic             all_ships_sunk;

    logic             preload_en;
    logic [6:0]       preload_addr;
    logic [1:0]       preload_data;

    always #5 clk = ~clk;

    shot_resolver #(.GRID_DIM(GRID_DIM), .SHIP_CELLS(SHIP_CELLS)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .shot_ready(shot_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .result_valid(result_valid), .result_hit(result_hit),
        .result_repeat(result_repeat), .result_invalid(result_invalid),
        .hit_count(hit_count), .all_ships_sunk(all_ships_sunk)
    );

    typedef struct {
        int         cyc;
        logic       hit;
        logic       rep;
        logic       inv;
        logic       we;
        logic [1:0] wdata;
        logic [6:0] addr;
        int         cnt;
        logic       sunk;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         results_seen = 0;
    int         model_cnt = 0;
    logic [1:0] shadow [0:127];
    logic [1:0] ram    [0:127];

    // Board RAM: one-cycle synchronous read, write port driven by the DUT.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (rst) begin
            for (int i = 0; i < 128; i++) ram[i] <= 2'b00;
        end else if (preload_en) begin
            ram[preload_addr] <= preload_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Result monitor: pops the scoreboard on every result pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (result_valid) begin
                results_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(result_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_cycle", 32'(cyc), 32'(e.cyc));
                    chk("result_hit", 32'(result_hit), 32'(e.hit));
                    chk("result_repeat", 32'(result_repeat), 32'(e.rep));
                    chk("result_invalid", 32'(result_invalid), 32'(e.inv));
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                    if (!e.inv) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("hit_count", 32'(hit_count), 32'(e.cnt));
                    chk("all_ships_sunk", 32'(all_ships_sunk), 32'(e.sunk));
                end
            end else begin
                chk("we_outside_result", 32'(mem_we), 32'd0);
            end
        end
    end

    // Reference model: outcome of one shot given the shadow board.
    task automatic predict(input int x, input int y, input int c);
        exp_t e;
        int   a;
        a = y * GRID_DIM + x;
        e.cyc = c + 3; e.hit = 1'b0; e.rep = 1'b0; e.inv = 1'b0;
        e.we = 1'b0; e.wdata = 2'b00; e.addr = a[6:0];
        if (x >= GRID_DIM || y >= GRID_DIM) begin
            e.inv = 1'b1;
        end else begin
            case (shadow[a])
                2'b00: begin e.we = 1'b1; e.wdata = 2'b10; shadow[a] = 2'b10; end
                2'b01: begin
                    e.we = 1'b1; e.wdata = 2'b11; e.hit = 1'b1; shadow[a] = 2'b11;
                    if (model_cnt < SHIP_CELLS) model_cnt++;
                end
                2'b10: e.rep = 1'b1;
                default: begin e.hit = 1'b1; e.rep = 1'b1; end
            endcase
        end
        e.cnt  = model_cnt;
        e.sunk = (model_cnt == SHIP_CELLS);
        exp_q.push_back(e);
    endtask

    task automatic preload(input int a, input logic [1:0] d);
        preload_en = 1'b1; preload_addr = 7'(a); preload_data = d;
        shadow[a] = d;
        @(posedge clk); #1;
        preload_en = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!shot_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(shot_ready), 32'd1);
    endtask

    task automatic shot(input int x, input int y);
        wait_ready("ready_before_shot");
        shot_x = 4'(x); shot_y = 4'(y); shot_valid = 1'b1;
        predict(x, y, cyc);
        @(posedge clk); #1;
        shot_valid = 1'b0;
        shot_x = 4'($urandom_range(0, 15));
        shot_y = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int seen0;
        for (int i = 0; i < 128; i++) shadow[i] = 2'b00;
        rst = 1'b1; clear = 1'b0; shot_valid = 1'b0; shot_x = 4'd0; shot_y = 4'd0;
        preload_en = 1'b0; preload_addr = 7'd0; preload_data = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_shot_ready", 32'(shot_ready), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_result_hit", 32'(result_hit), 32'd0);
        chk("rst_result_repeat", 32'(result_repeat), 32'd0);
        chk("rst_result_invalid", 32'(result_invalid), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_sunk", 32'(all_ships_sunk), 32'd0);
        rst = 1'b0;

        // Basic outcomes, repeats, out-of-range and corner coordinates.
        preload(45, 2'b01);
        shot(3, 2);
        shot(5, 4);
        shot(5, 4);
        shot(3, 2);
        shot(10, 3);
        shot(2, 15);
        shot(9, 9);
        shot(0, 0);
        drain();

        // clear during EVAL of a ship hit drops the shot entirely.
        preload(50, 2'b01);
        wait_ready("ready_clr");
        shot_x = 4'd0; shot_y = 4'd5; shot_valid = 1'b1;
        @(posedge clk); #1;
        shot_valid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("clr_result_valid", 32'(result_valid), 32'd0);
        chk("clr_mem_we", 32'(mem_we), 32'd0);
        chk("clr_hit_count", 32'(hit_count), 32'd0);
        chk("clr_shot_ready", 32'(shot_ready), 32'd1);
        shot(0, 5);
        drain();

        // shot_valid held for 12 cycles: three handshakes, four cycles apart.
        wait_ready("ready_hold");
        shot_x = 4'd1; shot_y = 4'd0; shot_valid = 1'b1;
        predict(1, 0, cyc);
        predict(1, 0, cyc + 4);
        predict(1, 0, cyc + 8);
        seen0 = results_seen;
        repeat (12) @(negedge clk);
        shot_valid = 1'b0;
        drain();
        chk("hold_results", 32'(results_seen - seen0), 32'd3);

        // Sink every ship cell from a fresh game.
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < SHIP_CELLS; i++) preload(60 + i, 2'b01);
        for (int i = 0; i < SHIP_CELLS; i++) shot(i % 10, 6 + i / 10);
        drain();
        seen0 = results_seen;
        shot_x = 4'd0; shot_y = 4'd0; shot_valid = 1'b1;
        repeat (8) @(negedge clk);
        chk("sunk_shot_ready", 32'(shot_ready), 32'd0);
        chk("sunk_hit_count", 32'(hit_count), 32'(SHIP_CELLS));
        chk("sunk_flag", 32'(all_ships_sunk), 32'd1);
        chk("sunk_no_results", 32'(results_seen - seen0), 32'd0);

        // clear and shot_valid together for two cycles: clear wins.
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0; shot_valid = 1'b0;
        model_cnt = 0;
        chk("prio_shot_ready", 32'(shot_ready), 32'd1);
        chk("prio_hit_count", 32'(hit_count), 32'd0);
        chk("prio_sunk", 32'(all_ships_sunk), 32'd0);
        repeat (6) @(negedge clk);
        chk("prio_no_results", 32'(results_seen - seen0), 32'd0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
